// File: rtl/note_mixer.sv
// Four-voice square-wave note mixer (BGM L/R + SFX L/R) with saturated stereo sum.
// Optional SFX_DUCK_EN: halve BGM voice samples while sfx_en is high.

module note_voice #(
  parameter int DIV_W   = 22,
  parameter int AMP_W   = 16,
  parameter int MIN_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [DIV_W-1:0]        div_in,
  input  logic [AMP_W-1:0]        amp_in,
  output logic signed [15:0]      sample
);
  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   div_lat;
  logic               phase;
  logic [14:0]        amp_lat;
  logic [14:0]        amp_clamped;
  logic               running;
  logic               div_ok;
  logic               at_wrap;
  logic signed [15:0] mag;

  assign running = div_lat >= DIV_W'(MIN_DIV);
  assign div_ok  = div_in >= DIV_W'(MIN_DIV);
  assign at_wrap = cnt == (div_lat - DIV_W'(1));

  always_comb begin
    amp_clamped = amp_in[14:0];
    if (amp_in > AMP_W'(32767)) amp_clamped = 15'h7fff;
  end

  // A too-small divider mutes immediately; otherwise changes land only at a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      phase   <= 1'b0;
      div_lat <= '0;
      amp_lat <= '0;
    end else if (clr || !div_ok) begin
      cnt     <= '0;
      phase   <= 1'b0;
      div_lat <= '0;
      amp_lat <= '0;
    end else if (!running) begin
      cnt     <= '0;
      phase   <= 1'b0;
      div_lat <= div_in;
      amp_lat <= amp_clamped;
    end else if (at_wrap) begin
      cnt     <= '0;
      phase   <= ~phase;
      div_lat <= div_in;
      amp_lat <= amp_clamped;
    end else begin
      cnt     <= cnt + DIV_W'(1);
    end
  end

  assign mag    = {1'b0, amp_lat};
  assign sample = !running ? 16'sd0 : (phase ? mag : -mag);
endmodule

module note_mixer #(
  parameter int DIV_W   = 22,
  parameter int AMP_W   = 16,
  parameter int MIN_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   bgm_note_div_left,
  input  logic [DIV_W-1:0]   bgm_note_div_right,
  input  logic [AMP_W-1:0]   bgm_amplitude,
  input  logic               sfx_en,
  input  logic [DIV_W-1:0]   sfx_note_div,
  input  logic [AMP_W-1:0]   sfx_amplitude,
  output logic [15:0]        audio_left,
  output logic [15:0]        audio_right
);
  logic signed [15:0] bgm_l, bgm_r, sfx_l, sfx_r;
  logic signed [15:0] bgm_l_m, bgm_r_m, sfx_l_g, sfx_r_g;
  logic signed [17:0] sum_l, sum_r;

  note_voice #(.DIV_W(DIV_W), .AMP_W(AMP_W), .MIN_DIV(MIN_DIV)) u_bgm_l (
    .clk(clk), .rst(rst), .clr(1'b0),
    .div_in(bgm_note_div_left), .amp_in(bgm_amplitude), .sample(bgm_l)
  );
  note_voice #(.DIV_W(DIV_W), .AMP_W(AMP_W), .MIN_DIV(MIN_DIV)) u_bgm_r (
    .clk(clk), .rst(rst), .clr(1'b0),
    .div_in(bgm_note_div_right), .amp_in(bgm_amplitude), .sample(bgm_r)
  );
  note_voice #(.DIV_W(DIV_W), .AMP_W(AMP_W), .MIN_DIV(MIN_DIV)) u_sfx_l (
    .clk(clk), .rst(rst), .clr(!sfx_en),
    .div_in(sfx_note_div), .amp_in(sfx_amplitude), .sample(sfx_l)
  );
  note_voice #(.DIV_W(DIV_W), .AMP_W(AMP_W), .MIN_DIV(MIN_DIV)) u_sfx_r (
    .clk(clk), .rst(rst), .clr(!sfx_en),
    .div_in(sfx_note_div), .amp_in(sfx_amplitude), .sample(sfx_r)
  );

  // SFX is gated combinationally so it drops out on the same edge sfx_en falls.
  assign sfx_l_g = sfx_en ? sfx_l : 16'sd0;
  assign sfx_r_g = sfx_en ? sfx_r : 16'sd0;

`ifdef SFX_DUCK_EN
  assign bgm_l_m = sfx_en ? (bgm_l >>> 1) : bgm_l;
  assign bgm_r_m = sfx_en ? (bgm_r >>> 1) : bgm_r;
`else
  assign bgm_l_m = bgm_l;
  assign bgm_r_m = bgm_r;
`endif

  assign sum_l = {{2{bgm_l_m[15]}}, bgm_l_m} + {{2{sfx_l_g[15]}}, sfx_l_g};
  assign sum_r = {{2{bgm_r_m[15]}}, bgm_r_m} + {{2{sfx_r_g[15]}}, sfx_r_g};

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'h7fff;
    else if (v < -18'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= sat16(sum_l);
      audio_right <= sat16(sum_r);
    end
  end
endmodule

// File: tb/tb_note_mixer.sv
// Directed self-checking bench for note_mixer (honours SFX_DUCK_EN when defined).

module tb_note_mixer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] bgm_note_div_left  = 22'd4;
  logic [21:0] bgm_note_div_right = 22'd4;
  logic [15:0] bgm_amplitude      = 16'd1000;
  logic        sfx_en             = 1'b0;
  logic [21:0] sfx_note_div       = 22'd0;
  logic [15:0] sfx_amplitude      = 16'd0;
  logic [15:0] audio_left;
  logic [15:0] audio_right;

  int n_checks = 0;
  int n_pass   = 0;

  note_mixer dut (
    .clk(clk), .rst(rst),
    .bgm_note_div_left(bgm_note_div_left), .bgm_note_div_right(bgm_note_div_right),
    .bgm_amplitude(bgm_amplitude), .sfx_en(sfx_en),
    .sfx_note_div(sfx_note_div), .sfx_amplitude(sfx_amplitude),
    .audio_left(audio_left), .audio_right(audio_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // n consecutive cycles with fixed left/right values, sampled on negedge
  task automatic run(input string tag, input int l, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_l"}, s16(audio_left), l);
      check({tag, "_r"}, s16(audio_right), r);
    end
  endtask

  task automatic restart(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run({tag, "_first"}, 0, 0, 1);
  endtask

  int duck_small;

  initial begin
`ifdef SFX_DUCK_EN
    duck_small = 15000;
`else
    duck_small = 20000;
`endif
    #1;
    check("rst_l", s16(audio_left), 0);
    check("rst_r", s16(audio_right), 0);

    // basic tone, div 4
    @(negedge clk); rst = 1'b0;
    run("t1_first", 0, 0, 1);
    for (int p = 0; p < 2; p++) begin
      run("t1_neg", -1000, -1000, 4);
      run("t1_pos", 1000, 1000, 4);
    end

    // BGM + SFX saturation
    bgm_note_div_left = 22'd10; bgm_note_div_right = 22'd10; bgm_amplitude = 16'd30000;
    sfx_en = 1'b1; sfx_note_div = 22'd10; sfx_amplitude = 16'd30000;
    restart("t2");
    run("t2_neg", -32768, -32768, 10);
    run("t2_pos", 32767, 32767, 10);
    run("t2_neg2", -32768, -32768, 10);

    bgm_amplitude = 16'd10000; sfx_amplitude = 16'd10000;
    restart("t2b");
    run("t2b_neg", -duck_small, -duck_small, 10);
    run("t2b_pos", duck_small, duck_small, 10);

    // amplitude clamp
    sfx_en = 1'b0; sfx_note_div = 22'd0; sfx_amplitude = 16'd0;
    bgm_note_div_left = 22'd6; bgm_note_div_right = 22'd6; bgm_amplitude = 16'hffff;
    restart("t3");
    run("t3_neg", -32767, -32767, 6);
    run("t3_pos", 32767, 32767, 6);

    // divider below MIN_DIV is silence
    bgm_note_div_left = 22'd1; bgm_note_div_right = 22'd1; bgm_amplitude = 16'd1000;
    restart("t_div1");
    run("t_div1", 0, 0, 6);

    // divider change takes effect at the half-period boundary
    bgm_note_div_left = 22'd8; bgm_note_div_right = 22'd8;
    restart("t4");
    run("t4_a", -1000, -1000, 3);
    bgm_note_div_left = 22'd20; bgm_note_div_right = 22'd20;
    run("t4_b", -1000, -1000, 5);
    run("t4_c", 1000, 1000, 20);
    run("t4_d", -1000, -1000, 4);

    // mute and restore
    bgm_note_div_left = 22'd8; bgm_note_div_right = 22'd8;
    restart("t5");
    run("t5_neg", -1000, -1000, 8);
    run("t5_pos", 1000, 1000, 2);
    bgm_note_div_left = 22'd0; bgm_note_div_right = 22'd0;
    run("t5_last", 1000, 1000, 1);
    run("t5_mute", 0, 0, 5);
    bgm_note_div_left = 22'd8; bgm_note_div_right = 22'd8;
    run("t5_latch", 0, 0, 1);
    run("t5_rneg", -1000, -1000, 8);
    run("t5_rpos", 1000, 1000, 8);

    // async reset mid-note
    run("t6_pre", -1000, -1000, 3);
    #2 rst = 1'b1;
    #1;
    check("t6_async_l", s16(audio_left), 0);
    check("t6_async_r", s16(audio_right), 0);
    @(negedge clk); rst = 1'b0;
    run("t6_first", 0, 0, 1);
    run("t6_neg", -1000, -1000, 8);
    run("t6_pos", 1000, 1000, 4);

    // left/right independence
    bgm_note_div_left = 22'd4; bgm_note_div_right = 22'd6;
    restart("t7");
    run("t7_a", -1000, -1000, 4);
    run("t7_b", 1000, -1000, 2);
    run("t7_c", 1000, 1000, 2);
    run("t7_d", -1000, 1000, 4);

    // SFX alone, gated by sfx_en
    bgm_note_div_left = 22'd0; bgm_note_div_right = 22'd0;
    sfx_en = 1'b1; sfx_note_div = 22'd4; sfx_amplitude = 16'd500;
    restart("t8");
    run("t8_neg", -500, -500, 4);
    run("t8_pos", 500, 500, 2);
    sfx_en = 1'b0;
    run("t8_off", 0, 0, 4);
    sfx_en = 1'b1;
    run("t8_latch", 0, 0, 1);
    run("t8_rneg", -500, -500, 4);
    run("t8_rpos", 500, 500, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/note_mixer.md
Name: note_mixer

Overview:
- Downstream stage of the BGM generator. Turns note dividers and amplitudes into signed 16-bit square-wave samples, left and right.
- Mixes two sources: BGM (always on) and SFX (gated by sfx_en), with saturation.
- Output feeds the speaker serializer as audio_left/audio_right.

Parameters:
- DIV_W, 22, width of note divider inputs (half-period length in clk cycles).
- AMP_W, 16, width of amplitude inputs (unsigned magnitude).
- MIN_DIV, 2, smallest divider that produces tone; any smaller value means silence.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-high reset
- bgm_note_div_left  input  DIV_W  BGM left half-period in cycles
- bgm_note_div_right  input  DIV_W  BGM right half-period in cycles
- bgm_amplitude  input  AMP_W  BGM magnitude, shared by both channels
- sfx_en  input  1  SFX source active
- sfx_note_div  input  DIV_W  SFX half-period, both channels
- sfx_amplitude  input  AMP_W  SFX magnitude
- audio_left  output  16  signed mixed left sample
- audio_right  output  16  signed mixed right sample

Behaviour:
- Voices: four independent voices (BGM-L, BGM-R, SFX-L, SFX-R).
- Voice state: cnt (DIV_W), phase (1 bit), div_lat (DIV_W), amp_lat (15 bits).
- Reset (async): every cnt, phase, div_lat and amp_lat goes to 0. audio_left and audio_right are 0 immediately, with no clock edge needed.
- Idle voice (div_lat < MIN_DIV):
  - Samples its div/amp inputs every cycle.
  - If the input div >= MIN_DIV, on that edge it latches div_lat and amp_lat and sets cnt=0, phase=0.
- Running voice:
  - cnt increments each cycle.
  - When cnt == div_lat-1: cnt resets to 0, phase toggles, and div_lat/amp_lat reload from the current inputs.
  - Result: full period = 2*div_lat cycles. Divider and amplitude changes take effect only at a half-period boundary, so no glitches.
- Mute: an input div < MIN_DIV on a running voice takes effect on the next edge, not at the boundary. The voice returns to idle (div_lat=0, cnt=0, phase=0).
- Amplitude clamp: the input is treated as unsigned. Values > 32767 latch as 32767.
- Voice sample:
  - phase=1 → +amp_lat; phase=0 → -amp_lat.
  - Idle voice → 0.
- SFX gating:
  - SFX voices contribute 0 while sfx_en=0.
  - While sfx_en=0, SFX voices are forced idle: reset state, counters held.
- Mix: 18-bit signed sum of the BGM and SFX samples per channel, saturated to [-32768, 32767].
- Latency: audio_* is registered. It reflects voice state from the previous edge, so there is 1 cycle of latency from a phase change to the output.
- Left/right independence: the channels are fully independent. Equal left/right dividers stay phase-aligned only if they start on the same edge.
- Simultaneous events:
  - Wrap and input change on the same edge: the new values are latched at that wrap.
  - sfx_en falling on an SFX wrap edge: idle wins.

Optional Feature:
- Macro: SFX_DUCK_EN.
- Defined: while sfx_en=1, each BGM voice sample is arithmetic-shifted right by 1 (-6 dB) before summing. Voice counters and timing are unaffected.
- Undefined: plain saturated sum, no ducking.

Test Plan:
- Reset then BGM div_left=div_right=4, amp=1000, sfx_en=0:
  - audio_left is 0 on the first cycle after release.
  - Then -1000 for 4 cycles, +1000 for 4 cycles, repeating with period 8. audio_right is identical.
- BGM div=10, amp=30000 with sfx_en=1, sfx div=10, sfx amp=30000, started on the same edge:
  - Output alternates -32768 / +32767 every 10 cycles.
  - With SFX_DUCK_EN: -32768 and +32767 still (15000+30000 saturates).
  - With amps 10000/10000 under SFX_DUCK_EN: ±15000.
- bgm_amplitude=16'hFFFF, div=6 → outputs ±32767.
- BGM div=8 running; change to 20 at cnt=3 → current half-period still lasts 8 cycles, later halves last 20.
- BGM div=8 running; set div=0 → output 0 from the second edge after the change. Restore 8 → restarts at -amp on phase 0.
- Assert rst asynchronously mid-note → audio_left/right go 0 before the next clk edge. After release the tone restarts from phase 0.
